// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared encodings for the byte-wide RAM arbiter of the RV32I pipeline:
//   arb_state_t : arbiter FSM states (ARB_IDLE/READ/WRITE/DONE)
//   owner_t     : which requester holds the RAM port (OWN_IF/OWN_MEM)
//   MEM_SIZE_*  : mem_size codes driven by the MEM stage
//   size_to_bytes() : size code -> byte count (code 3 behaves as a word)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_READ  = 2'd1,
      ARB_WRITE = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;

   function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
      case (size)
         MEM_SIZE_B: return 3'd1;
         MEM_SIZE_H: return 3'd2;
         default:    return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one byte-wide RAM port between instruction fetch (IF) and the MEM
// stage. Accesses of 1/2/4 bytes are serialised into byte cycles; read bytes
// are assembled little-endian, store data is emitted low byte first.
//
// Handshake: a requester raises req with stable address/data and holds it
// until its rdy pulses for exactly one cycle (the DONE state); it drops req
// in that cycle. IF may instead withdraw via i_if_flush, which also aborts an
// IF-owned read in flight without any rdy pulse. MEM wins simultaneous
// requests. Requests are only sampled in IDLE.
//
// Ports:
//   i_clk, rst          clock / synchronous active-high reset
//   i_if_*              fetch request (always 4 bytes), flush
//   o_if_rdy, o_if_data fetch completion pulse and word
//   i_mem_*             data request: we, size, addr, wdata
//   o_mem_rdy, o_mem_rdata  data completion pulse and zero-extended load data
//   o_ram_*, i_ram_din  byte RAM port (read data one cycle after address)
//   o_state             current FSM state (debug)
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW = 17
) (
   input  logic          i_clk,
   input  logic          rst,
   input  logic          i_if_req,
   input  logic [31:0]   i_if_addr,
   input  logic          i_if_flush,
   output logic          o_if_rdy,
   output logic [31:0]   o_if_data,
   input  logic          i_mem_req,
   input  logic          i_mem_we,
   input  logic [1:0]    i_mem_size,
   input  logic [31:0]   i_mem_addr,
   input  logic [31:0]   i_mem_wdata,
   output logic          o_mem_rdy,
   output logic [31:0]   o_mem_rdata,
   output logic [AW-1:0] o_ram_addr,
   output logic          o_ram_wr,
   output logic [7:0]    o_ram_dout,
   input  logic [7:0]    i_ram_din,
   output arb_state_t    o_state
);

   arb_state_t    r_state,    w_state_nxt;
   owner_t        r_owner,    w_owner_nxt;
   logic [AW-1:0] r_base,     w_base_nxt;
   logic [2:0]    r_nbytes,   w_nbytes_nxt;
   logic [2:0]    r_cnt,      w_cnt_nxt;
   logic [31:0]   r_wdata,    w_wdata_nxt;
   logic [31:0]   r_asm,      w_asm_nxt;
   logic          r_if_rdy,   w_if_rdy_nxt;
   logic          r_mem_rdy,  w_mem_rdy_nxt;
   logic [31:0]   r_if_data,  w_if_data_nxt;
   logic [31:0]   r_mem_rdata, w_mem_rdata_nxt;
   logic [AW-1:0] r_ram_addr, w_ram_addr_nxt;
   logic          r_ram_wr,   w_ram_wr_nxt;
   logic [7:0]    r_ram_dout, w_ram_dout_nxt;

   logic [2:0]    w_cnt_p1;
   logic [2:0]    w_cnt_m1;
   logic [31:0]   w_asm_ins;
   logic          w_unused;

   // Upper address bits beyond the RAM are intentionally dropped.
   assign w_unused = ^{i_if_addr[31:AW], i_mem_addr[31:AW]};

   assign w_cnt_p1 = r_cnt + 3'd1;
   assign w_cnt_m1 = r_cnt - 3'd1;

   // In READ, the byte on i_ram_din during count c belongs to lane c-1
   // (RAM latency is one cycle); count 0 has nothing to capture yet.
   always_comb begin
      w_asm_ins = r_asm;
      if (r_cnt != 3'd0) begin
         w_asm_ins[{w_cnt_m1[1:0], 3'b000} +: 8] = i_ram_din;
      end
   end

   always_ff @(posedge i_clk) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_owner     <= OWN_IF;
         r_base      <= '0;
         r_nbytes    <= '0;
         r_cnt       <= '0;
         r_wdata     <= '0;
         r_asm       <= '0;
         r_if_rdy    <= 1'b0;
         r_mem_rdy   <= 1'b0;
         r_if_data   <= '0;
         r_mem_rdata <= '0;
         r_ram_addr  <= '0;
         r_ram_wr    <= 1'b0;
         r_ram_dout  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_base      <= w_base_nxt;
         r_nbytes    <= w_nbytes_nxt;
         r_cnt       <= w_cnt_nxt;
         r_wdata     <= w_wdata_nxt;
         r_asm       <= w_asm_nxt;
         r_if_rdy    <= w_if_rdy_nxt;
         r_mem_rdy   <= w_mem_rdy_nxt;
         r_if_data   <= w_if_data_nxt;
         r_mem_rdata <= w_mem_rdata_nxt;
         r_ram_addr  <= w_ram_addr_nxt;
         r_ram_wr    <= w_ram_wr_nxt;
         r_ram_dout  <= w_ram_dout_nxt;
      end
   end

   // Next-state logic computes the next value of every register so that all
   // outputs leave flops; no req input reaches a RAM output combinationally.
   always_comb begin
      w_state_nxt     = r_state;
      w_owner_nxt     = r_owner;
      w_base_nxt      = r_base;
      w_nbytes_nxt    = r_nbytes;
      w_cnt_nxt       = r_cnt;
      w_wdata_nxt     = r_wdata;
      w_asm_nxt       = r_asm;
      w_if_rdy_nxt    = 1'b0;
      w_mem_rdy_nxt   = 1'b0;
      w_if_data_nxt   = r_if_data;
      w_mem_rdata_nxt = r_mem_rdata;
      w_ram_addr_nxt  = r_ram_addr;
      w_ram_wr_nxt    = 1'b0;
      w_ram_dout_nxt  = r_ram_dout;

      case (r_state)
         ARB_IDLE: begin
            w_cnt_nxt = 3'd0;
            if (i_mem_req) begin
               w_owner_nxt    = OWN_MEM;
               w_base_nxt     = i_mem_addr[AW-1:0];
               w_nbytes_nxt   = size_to_bytes(i_mem_size);
               w_asm_nxt      = '0;
               w_ram_addr_nxt = i_mem_addr[AW-1:0];
               if (i_mem_we) begin
                  // Byte 0 goes out on the grant edge; the shift register
                  // then presents the following byte in its low lane.
                  w_state_nxt    = ARB_WRITE;
                  w_ram_wr_nxt   = 1'b1;
                  w_ram_dout_nxt = i_mem_wdata[7:0];
                  w_wdata_nxt    = i_mem_wdata >> 8;
               end else begin
                  w_state_nxt = ARB_READ;
               end
            end else if (i_if_req && !i_if_flush) begin
               w_owner_nxt    = OWN_IF;
               w_base_nxt     = i_if_addr[AW-1:0];
               w_nbytes_nxt   = 3'd4;
               w_asm_nxt      = '0;
               w_ram_addr_nxt = i_if_addr[AW-1:0];
               w_state_nxt    = ARB_READ;
            end
         end

         ARB_READ: begin
            if (r_owner == OWN_IF && i_if_flush) begin
               w_state_nxt = ARB_IDLE;
            end else begin
               w_cnt_nxt = w_cnt_p1;
               w_asm_nxt = w_asm_ins;
               if (w_cnt_p1 < r_nbytes) begin
                  w_ram_addr_nxt = r_base + AW'(w_cnt_p1);
               end
               if (r_cnt == r_nbytes) begin
                  w_state_nxt = ARB_DONE;
                  w_cnt_nxt   = 3'd0;
                  if (r_owner == OWN_IF) begin
                     w_if_rdy_nxt  = 1'b1;
                     w_if_data_nxt = w_asm_ins;
                  end else begin
                     w_mem_rdy_nxt   = 1'b1;
                     w_mem_rdata_nxt = w_asm_ins;
                  end
               end
            end
         end

         ARB_WRITE: begin
            if (w_cnt_p1 < r_nbytes) begin
               w_cnt_nxt      = w_cnt_p1;
               w_ram_wr_nxt   = 1'b1;
               w_ram_addr_nxt = r_base + AW'(w_cnt_p1);
               w_ram_dout_nxt = r_wdata[7:0];
               w_wdata_nxt    = r_wdata >> 8;
            end else begin
               w_state_nxt   = ARB_DONE;
               w_cnt_nxt     = 3'd0;
               w_mem_rdy_nxt = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   assign o_if_rdy    = r_if_rdy;
   assign o_if_data   = r_if_data;
   assign o_mem_rdy   = r_mem_rdy;
   assign o_mem_rdata = r_mem_rdata;
   assign o_ram_addr  = r_ram_addr;
   assign o_ram_wr    = r_ram_wr;
   assign o_ram_dout  = r_ram_dout;
   assign o_state     = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a byte RAM model (one-cycle read
// latency). Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 17;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          i_if_req = 1'b0;
   logic [31:0]   i_if_addr = '0;
   logic          i_if_flush = 1'b0;
   logic          o_if_rdy;
   logic [31:0]   o_if_data;
   logic          i_mem_req = 1'b0;
   logic          i_mem_we = 1'b0;
   logic [1:0]    i_mem_size = '0;
   logic [31:0]   i_mem_addr = '0;
   logic [31:0]   i_mem_wdata = '0;
   logic          o_mem_rdy;
   logic [31:0]   o_mem_rdata;
   logic [AW-1:0] o_ram_addr;
   logic          o_ram_wr;
   logic [7:0]    o_ram_dout;
   logic [7:0]    i_ram_din;
   arb_state_t    o_state;

   mem_arbiter #(.AW(AW)) dut (
      .i_clk       (clk),
      .rst         (rst),
      .i_if_req    (i_if_req),
      .i_if_addr   (i_if_addr),
      .i_if_flush  (i_if_flush),
      .o_if_rdy    (o_if_rdy),
      .o_if_data   (o_if_data),
      .i_mem_req   (i_mem_req),
      .i_mem_we    (i_mem_we),
      .i_mem_size  (i_mem_size),
      .i_mem_addr  (i_mem_addr),
      .i_mem_wdata (i_mem_wdata),
      .o_mem_rdy   (o_mem_rdy),
      .o_mem_rdata (o_mem_rdata),
      .o_ram_addr  (o_ram_addr),
      .o_ram_wr    (o_ram_wr),
      .o_ram_dout  (o_ram_dout),
      .i_ram_din   (i_ram_din),
      .o_state     (o_state)
   );

   // ---------------- RAM model + pulse counters ----------------
   logic [7:0]    ram [0:(1<<AW)-1];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [7:0]    pl_data = '0;
   int            if_rdy_cnt = 0;
   int            mem_rdy_cnt = 0;

   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      else if (o_ram_wr) ram[o_ram_addr] <= o_ram_dout;
      i_ram_din <= ram[o_ram_addr];
      if (o_if_rdy) if_rdy_cnt <= if_rdy_cnt + 1;
      if (o_mem_rdy) mem_rdy_cnt <= mem_rdy_cnt + 1;
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic mem_issue(input logic we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
      i_mem_req = 1'b1; i_mem_we = we; i_mem_size = size;
      i_mem_addr = addr; i_mem_wdata = wdata;
   endtask

   // Steps until the selected rdy is high or the budget runs out.
   task automatic wait_rdy(input bit use_mem, input int budget, output int n);
      n = 0;
      while (!(use_mem ? o_mem_rdy : o_if_rdy) && n < budget) begin
         tick();
         n++;
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int n;
      int cnt0;

      // reset + RAM preload (DUT held in reset meanwhile)
      tick();
      preload(17'h00100, 8'h13); preload(17'h00101, 8'h00);
      preload(17'h00102, 8'h50); preload(17'h00103, 8'h00);
      preload(17'h00020, 8'h8F);
      preload(17'h00200, 8'h11); preload(17'h00201, 8'h22);
      preload(17'h00202, 8'h33); preload(17'h00203, 8'h44);
      preload(17'h00001, 8'h5A); preload(17'h00402, 8'hEE);
      check("rst_state", 32'(o_state), 32'(ARB_IDLE));
      check("rst_rdy", {30'd0, o_if_rdy, o_mem_rdy}, 32'd0);
      check("rst_ram_wr", 32'(o_ram_wr), 32'd0);
      check("rst_ram_addr", 32'(o_ram_addr), 32'd0);
      check("rst_if_data", o_if_data, 32'd0);
      check("rst_mem_rdata", o_mem_rdata, 32'd0);
      rst = 1'b0;
      tick();

      // ---- IF word read @0x100 ----
      i_if_req = 1'b1; i_if_addr = 32'h100;                 // cycle T
      for (int k = 0; k < 4; k++) begin
         tick();                                             // T+1+k
         check("if_rd_addr", 32'(o_ram_addr), 32'h100 + 32'(k));
         check("if_rd_wr", {31'd0, o_ram_wr} | {31'd0, o_if_rdy}, 32'd0);
      end
      tick();                                                // T+5
      check("if_rd_nordy_t5", 32'(o_if_rdy), 32'd0);
      tick();                                                // T+6
      check("if_rd_rdy_t6", 32'(o_if_rdy), 32'd1);
      check("if_rd_data", o_if_data, 32'h00500013);
      i_if_req = 1'b0;
      tick();                                                // T+7
      check("if_rd_rdy_drop", 32'(o_if_rdy), 32'd0);
      check("if_rd_idle", 32'(o_state), 32'(ARB_IDLE));

      // ---- simultaneous IF + MEM load byte @0x20 ----
      i_if_req = 1'b1; i_if_addr = 32'h100;
      mem_issue(1'b0, MEM_SIZE_B, 32'h20, 32'h0);            // T
      tick();                                                // T+1
      check("sim_mem_first_addr", 32'(o_ram_addr), 32'h20);
      tick();                                                // T+2
      check("sim_read_t2", 32'(o_state), 32'(ARB_READ));
      tick();                                                // T+3
      check("sim_mem_rdy", 32'(o_mem_rdy), 32'd1);
      check("sim_mem_rdata", o_mem_rdata, 32'h0000008F);
      check("sim_if_nordy", 32'(o_if_rdy), 32'd0);
      i_mem_req = 1'b0;
      tick();                                                // T+4
      check("sim_idle_t4", 32'(o_state), 32'(ARB_IDLE));
      tick();                                                // T+5
      check("sim_if_grant_addr", 32'(o_ram_addr), 32'h100);
      wait_rdy(1'b0, 20, n);
      check("sim_if_lat", 32'(n), 32'd5);
      check("sim_if_data", o_if_data, 32'h00500013);
      i_if_req = 1'b0;
      tick();

      // ---- store half @0x1FFFF with address wrap ----
      mem_issue(1'b1, MEM_SIZE_H, 32'h1FFFF, 32'hAABBCCDD);  // T
      tick();                                                // T+1
      check("st_b0", {o_ram_wr, 7'd0, o_ram_dout, 15'd0, o_ram_addr},
            {1'b1, 7'd0, 8'hDD, 15'd0, 17'h1FFFF});
      tick();                                                // T+2
      check("st_b1_wrap", {o_ram_wr, 7'd0, o_ram_dout, 15'd0, o_ram_addr},
            {1'b1, 7'd0, 8'hCC, 15'd0, 17'h00000});
      tick();                                                // T+3
      check("st_rdy_t3", {30'd0, o_mem_rdy, o_ram_wr}, 32'd2);
      i_mem_req = 1'b0;
      tick();
      check("st_ram_1ffff", 32'(ram[17'h1FFFF]), 32'hDD);
      check("st_ram_0", 32'(ram[17'h00000]), 32'hCC);
      check("st_ram_1_kept", 32'(ram[17'h00001]), 32'h5A);

      // ---- flush mid-fetch, then refetch @0x200 ----
      cnt0 = if_rdy_cnt;
      i_if_req = 1'b1; i_if_addr = 32'h300;                  // T
      tick(); tick(); tick();                                // T+3
      check("fl_read_t3", 32'(o_state), 32'(ARB_READ));
      i_if_flush = 1'b1; i_if_addr = 32'h200;
      tick();                                                // T+4
      check("fl_idle_t4", 32'(o_state), 32'(ARB_IDLE));
      check("fl_nordy", 32'(o_if_rdy), 32'd0);
      check("fl_data_kept", o_if_data, 32'h00500013);
      i_if_flush = 1'b0;
      tick();                                                // T+5
      check("fl_regrant_addr", 32'(o_ram_addr), 32'h200);
      wait_rdy(1'b0, 20, n);
      check("fl_refetch_lat", 32'(n), 32'd5);
      check("fl_refetch_data", o_if_data, 32'h44332211);
      i_if_req = 1'b0;
      tick();
      check("fl_one_pulse", 32'(if_rdy_cnt - cnt0), 32'd1);

      // ---- size 3 load behaves as word ----
      mem_issue(1'b0, 2'd3, 32'h200, 32'h0);                 // T
      for (int k = 0; k < 4; k++) begin
         tick();
         check("sz3_addr", 32'(o_ram_addr), 32'h200 + 32'(k));
      end
      tick();                                                // T+5
      check("sz3_nordy_t5", 32'(o_mem_rdy), 32'd0);
      tick();                                                // T+6
      check("sz3_rdy_t6", 32'(o_mem_rdy), 32'd1);
      check("sz3_rdata", o_mem_rdata, 32'h44332211);
      i_mem_req = 1'b0;
      tick();

      // ---- half load @0x201 ----
      mem_issue(1'b0, MEM_SIZE_H, 32'h201, 32'h0);           // T
      wait_rdy(1'b1, 20, n);
      check("lh_lat", 32'(n), 32'd4);
      check("lh_rdata", o_mem_rdata, 32'h00003322);
      i_mem_req = 1'b0;
      tick();

      // ---- reset during a word store at its 2nd byte ----
      cnt0 = mem_rdy_cnt;
      mem_issue(1'b1, MEM_SIZE_W, 32'h400, 32'h12345678);    // T
      tick();                                                // T+1
      check("rs_b0", {o_ram_wr, 7'd0, o_ram_dout, 15'd0, o_ram_addr},
            {1'b1, 7'd0, 8'h78, 15'd0, 17'h00400});
      tick();                                                // T+2
      check("rs_b1", {o_ram_wr, 7'd0, o_ram_dout, 15'd0, o_ram_addr},
            {1'b1, 7'd0, 8'h56, 15'd0, 17'h00401});
      rst = 1'b1;
      tick();                                                // T+3
      check("rs_ram_wr", 32'(o_ram_wr), 32'd0);
      check("rs_ram_addr", 32'(o_ram_addr), 32'd0);
      check("rs_ram_dout", 32'(o_ram_dout), 32'd0);
      check("rs_data", o_if_data | o_mem_rdata, 32'd0);
      check("rs_rdy", {30'd0, o_if_rdy, o_mem_rdy}, 32'd0);
      check("rs_state", 32'(o_state), 32'(ARB_IDLE));
      rst = 1'b0; i_mem_req = 1'b0;
      tick(); tick(); tick();
      check("rs_no_rdy", 32'(mem_rdy_cnt - cnt0), 32'd0);
      check("rs_ram_400", 32'(ram[17'h00400]), 32'h78);
      check("rs_ram_401", 32'(ram[17'h00401]), 32'h56);
      check("rs_ram_402", 32'(ram[17'h00402]), 32'hEE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage of the five-stage RV32I pipeline. Each requester presents a 1/2/4-byte access and holds its request until a one-cycle ready pulse. The arbiter serialises the access into byte cycles, assembles or splits data little-endian, and supports aborting an in-flight fetch on a branch flush. IF and MEM stall on `!rdy`; this block creates no stall signals itself.

## Interface
- `AW`, default 17: RAM byte-address width; requester addresses are truncated to `AW` bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `if_req` in 1: fetch request; always 4 bytes; held until `if_rdy` or a flush.
- `if_addr` in 32: fetch byte address.
- `if_flush` in 1: cancel any pending or in-flight fetch (branch taken in ID).
- `if_rdy` out 1: one-cycle pulse; `if_data` valid.
- `if_data` out 32: fetched word.
- `mem_req` in 1: data request; held until `mem_rdy`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `mem_addr` in 32: data byte address.
- `mem_wdata` in 32: store data; low bytes are used first.
- `mem_rdy` out 1: one-cycle pulse; access complete.
- `mem_rdata` out 32: load data, zero-extended raw bytes. Sign extension is done by MEM.
- `ram_addr` out AW: RAM byte address.
- `ram_wr` out 1: RAM write strobe.
- `ram_dout` out 8: RAM write byte.
- `ram_din` in 8: RAM read byte; valid one cycle after `ram_addr` is presented with `ram_wr=0`.

## Operation
- State machine states: IDLE, READ, WRITE, DONE.
- **IDLE**
  - `mem_req` has priority over `if_req`. MEM always belongs to an older instruction.
  - If `if_flush` is high in the same cycle, `if_req` is ignored.
  - On grant, the arbiter latches the owner, base address, byte count N (1/2/4), write data and direction.
  - Next state is READ (load or fetch) or WRITE (store). The byte counter `i` is cleared.
- **READ**
  - `ram_addr` = base+i for i = 0..N-1 in consecutive cycles.
  - Byte i, returned one cycle later, is written into bits [8i+7:8i] of the assembly register.
  - The state stays in READ for N+1 cycles. The final cycle captures the last byte while `ram_addr` holds base+N-1.
  - After the last capture, the next state is DONE.
- **WRITE**
  - `ram_wr`=1, `ram_addr`=base+i, `ram_dout`=wdata[8i+7:8i] for i = 0..N-1.
  - After N cycles, the next state is DONE.
- **DONE**
  - The owner's rdy is high for exactly this cycle, with its data register valid.
  - New requests are not sampled; the requester drops its req in this cycle.
  - Next state is IDLE.
- **Flush**
  - If the owner is IF and `if_flush`=1 in READ, the next state is IDLE.
  - In that case `if_rdy` is never raised and `if_data` is unchanged.
  - If the flush falls in DONE, the pulse still occurs; IF discards it.
  - Flush has no effect on MEM-owned accesses.
- **Address wrap**: base+i wraps modulo 2^AW.
- Outside READ/WRITE, `ram_wr`=0, and `ram_addr`/`ram_dout` hold their last values.
- **Reset**
  - Values: state IDLE; `if_rdy`, `mem_rdy`, `ram_wr` = 0; `ram_addr`, `ram_dout`, `if_data`, `mem_rdata` = 0.
  - Reset mid-access aborts the access with no rdy pulse. A partially written store remains in RAM.

## Timing
- Request sampled high in IDLE at cycle T:
  - First RAM address in T+1.
  - Read: rdy at T+N+2 and IDLE at T+N+3, so a word read occupies 7 cycles from T through T+6.
  - Write: `ram_wr` high T+1..T+N, rdy at T+N+1, IDLE at T+N+2.
- Back-to-back requests: the earliest next grant sample is the IDLE cycle after DONE.
- All outputs are registered. No combinational path exists from any req to any RAM output.

## Structure
- Shared package / define file additions:
  - State encodings `ARB_IDLE`, `ARB_READ`, `ARB_WRITE`, `ARB_DONE`.
  - Size codes `MEM_SIZE_B`, `MEM_SIZE_H`, `MEM_SIZE_W`.
  - Owner codes `OWN_IF`, `OWN_MEM`.
- Single flat module. No sub-module is warranted; the byte counter and assembly register are inline.

## Test plan
- **IF word read**: RAM[0x100..0x103] = 13 00 50 00; `if_req`@0x100 at T → `ram_addr` 0x100..0x103 at T+1..T+4; `if_rdy` at T+6 only, `if_data`=0x00500013.
- **Simultaneous requests**: `if_req` and `mem_req` (load byte @0x20, RAM=0x8F) in the same cycle → MEM served first, `mem_rdata`=0x0000008F; the IF grant sample follows in the IDLE cycle after `mem_rdy`.
- **Store half**: @0x1FFFF (AW=17), wdata=0xAABBCCDD → `ram_wr` at 0x1FFFF=DD then 0x00000=CC (wrap); `mem_rdy` at T+3.
- **Flush**: flush mid-fetch at T+3 → state IDLE at T+4; no `if_rdy` pulse ever; a new `if_req`@0x200 is granted at its next IDLE sample.
- **Reset mid-store**: `rst` during a word store at its 2nd byte → `ram_wr`=0 next cycle, all outputs 0, no `mem_rdy`.
- **Size 3**: `mem_size`=3 load → 4 bytes read, identical to a word load.
